// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word/bit handshake bundle for bit_serializer
// Purpose: groups the parallel word input handshake and the serial bit output
//          handshake of bit_serializer into one bundle.
// Signals:
//   in_valid, in_ready, in_data[WIDTH-1:0]  word handshake (upstream -> serializer)
//   out_bit, out_valid, out_ready           serial bit handshake (serializer -> downstream)
//   out_first, out_last                     word boundary markers on the serial side
//   busy                                    word in flight
// Modports:
//   slave  - the serializer side (takes words, produces bits)
//   master - the environment side (supplies words, consumes bits)
interface bit_serializer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_last;
  logic             busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_bit, out_valid, out_first, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_bit, out_valid, out_first, out_last, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end for the bit-sliced datapath
// Purpose: accepts a WIDTH-bit word over a valid/ready handshake and emits it
//          one bit per cycle with first/last markers and downstream back-pressure.
// Parameters:
//   WIDTH     word width in bits (1..64)
//   MSB_FIRST 0 = bit 0 emitted first, 1 = bit WIDTH-1 emitted first
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    bit_serializer_if.slave (word in, serial bit out, markers, busy)
module bit_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  bit_serializer_if.slave      bus
);

  localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
  localparam int              OUT_IDX = MSB_FIRST ? (WIDTH - 1) : 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             in_ready_c;
  logic             accept;
  logic             xfer;
  logic             at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    at_last    = (cnt == LAST);
    xfer       = (state == SHIFT) && bus.out_ready;
    // A new word may be taken while the final bit of the current word leaves,
    // which keeps back-to-back words gap-free. Depends on out_ready only,
    // never on in_valid.
    in_ready_c = (state == IDLE) || (xfer && at_last);
    accept     = bus.in_valid && in_ready_c;

    if (accept) begin
      state_n = SHIFT;
      shreg_n = bus.in_data;
      cnt_n   = '0;
    end else if (xfer) begin
      // Shift toward the output end with zero fill; on the last bit this
      // also leaves the register cleared for the return to IDLE.
      shreg_n = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      if (at_last) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n   = cnt + CW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == SHIFT);
  assign bus.busy      = (state == SHIFT);
  assign bus.out_bit   = (state == SHIFT) && shreg[OUT_IDX];
  assign bus.out_first = (state == SHIFT) && (cnt == '0);
  assign bus.out_last  = (state == SHIFT) && at_last;

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed self-checking bench for bit_serializer
// Purpose: drives three builds (WIDTH=8 LSB-first, WIDTH=8 MSB-first, WIDTH=1)
//          with hand-computed vectors and prints one summary line.
module tb_bit_serializer;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  bit_serializer_if #(.WIDTH(8)) if_a ();
  bit_serializer_if #(.WIDTH(8)) if_b ();
  bit_serializer_if #(.WIDTH(1)) if_c ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b0)) u_c (.clk(clk), .reset(reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int sel, input logic v, input logic [7:0] d, input logic r);
    case (sel)
      0: begin if_a.in_valid = v; if_a.in_data = d; if_a.out_ready = r; end
      1: begin if_b.in_valid = v; if_b.in_data = d; if_b.out_ready = r; end
      default: begin if_c.in_valid = v; if_c.in_data = d[0]; if_c.out_ready = r; end
    endcase
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return if_a.in_ready;
      1:       return if_b.in_ready;
      default: return if_c.in_ready;
    endcase
  endfunction

  task automatic expect_out(input int sel, input string tag,
                            input logic v, input logic b, input logic f, input logic l);
    logic [4:0] o;
    case (sel)
      0:       o = {if_a.out_valid, if_a.out_bit, if_a.out_first, if_a.out_last, if_a.busy};
      1:       o = {if_b.out_valid, if_b.out_bit, if_b.out_first, if_b.out_last, if_b.busy};
      default: o = {if_c.out_valid, if_c.out_bit, if_c.out_first, if_c.out_last, if_c.busy};
    endcase
    check({tag, "_valid"}, 64'(o[4]), 64'(v));
    check({tag, "_bit"},   64'(o[3]), 64'(b));
    check({tag, "_first"}, 64'(o[2]), 64'(f));
    check({tag, "_last"},  64'(o[1]), 64'(l));
    check({tag, "_busy"},  64'(o[0]), 64'(v));
  endtask

  // seq[i] is the i-th bit expected on out_bit after the accept.
  task automatic word8(input int sel, input logic [7:0] d, input logic [7:0] seq, input string tag);
    @(negedge clk);
    check({tag, "_idle_rdy"}, 64'(rdy(sel)), 64'd1);
    drv(sel, 1'b1, d, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) drv(sel, 1'b0, ~d, 1'b1);
      expect_out(sel, $sformatf("%s_b%0d", tag, i), 1'b1, seq[i], i == 0, i == 7);
      if (i == 3) check({tag, "_mid_rdy"}, 64'(rdy(sel)), 64'd0);
    end
    @(negedge clk);
    expect_out(sel, {tag, "_end"}, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_end_rdy"}, 64'(rdy(sel)), 64'd1);
  endtask

  initial begin
    int idx;
    logic [7:0] seq;
    reset = 1'b0;
    drv(0, 1'b0, 8'h00, 1'b0);
    drv(1, 1'b0, 8'h00, 1'b0);
    drv(2, 1'b0, 8'h00, 1'b0);
    #1;
    expect_out(0, "rst_a", 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(1, "rst_b", 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(2, "rst_c", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_rdy_a", 64'(if_a.in_ready), 64'd1);
    check("rst_rdy_c", 64'(if_c.in_ready), 64'd1);

    // LSB-first A5: 1,0,1,0,0,1,0,1
    word8(0, 8'hA5, 8'hA5, "lsb_a5");
    // MSB-first A5 read MSB->LSB: 1,0,1,0,0,1,0,1
    word8(1, 8'hA5, 8'hA5, "msb_a5");
    // MSB-first 01: seven 0s then 1
    word8(1, 8'h01, 8'h80, "msb_01");

    // Back-to-back FF then 00 with in_valid held high
    @(negedge clk);
    drv(0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      expect_out(0, $sformatf("b2b_%0d", i), 1'b1, i < 8, (i == 0) || (i == 8), (i == 7) || (i == 15));
      if (i == 0) drv(0, 1'b1, 8'h00, 1'b1);
      if (i == 3) check("b2b_mid_rdy", 64'(if_a.in_ready), 64'd0);
      if (i == 7) check("b2b_last_rdy", 64'(if_a.in_ready), 64'd1);
      if (i == 8) drv(0, 1'b0, 8'h00, 1'b1);
    end
    @(negedge clk);
    expect_out(0, "b2b_end", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall three cycles on bit 2 of 3C (LSB-first 0,0,1,1,1,1,0,0)
    seq = 8'h3C;
    @(negedge clk);
    drv(0, 1'b1, 8'h3C, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) if_a.in_valid = 1'b0;
      idx = (k < 2) ? k : ((k <= 5) ? 2 : k - 3);
      if (k < 11) expect_out(0, $sformatf("stall_%0d", k), 1'b1, seq[idx], idx == 0, idx == 7);
      else        expect_out(0, "stall_end", 1'b0, 1'b0, 1'b0, 1'b0);
      if_a.out_ready = !((k >= 2) && (k <= 4));
    end

    // Reset mid-word after bit 4 of C3 (LSB-first 1,1,0,0,0,0,1,1)
    seq = 8'hC3;
    @(negedge clk);
    drv(0, 1'b1, 8'hC3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) if_a.in_valid = 1'b0;
      expect_out(0, $sformatf("rmid_%0d", k), 1'b1, seq[k], k == 0, 1'b0);
    end
    #2 reset = 1'b0;
    #1 expect_out(0, "rmid_async", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rmid_rdy", 64'(if_a.in_ready), 64'd1);
    word8(0, 8'h81, 8'h81, "post_rst_81");

    // WIDTH=1 build: 1,0,1 back-to-back
    @(negedge clk);
    drv(2, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_out(2, $sformatf("w1_%0d", i), 1'b1, i != 1, 1'b1, 1'b1);
      check($sformatf("w1_rdy_%0d", i), 64'(if_c.in_ready), 64'd1);
      if (i == 0) drv(2, 1'b1, 8'h00, 1'b1);
      if (i == 1) drv(2, 1'b1, 8'h01, 1'b1);
      if (i == 2) drv(2, 1'b0, 8'h00, 1'b1);
    end
    @(negedge clk);
    expect_out(2, "w1_end", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
